// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Step-clock enable source for the single-cycle processor. The raw active-low
//   step key is synchronized (two flops), debounced by a four-state FSM with a
//   single shared counter, and turned into exactly one StepPulse per accepted
//   press. Halt suppresses pulses without stopping the debouncer.
//
//   Optional feature (macro STEP_PULSE_AUTO_RUN_EN): with RunMode=1 a prescaler
//   issues one StepPulse every RUN_DIV cycles and manual pulses are suppressed.
//   Without the macro RunMode is ignored and no prescaler exists.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples to accept a press/release (>=2)
//   RUN_DIV          cycles between auto-run pulses (>=2)
//   CNT_W            width of StepCount
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   ResetN     in   synchronous reset, active-low
//   StepKeyN   in   raw pushbutton, asynchronous, 0 = pressed
//   RunMode    in   1 = auto-run (feature build only), 0 = manual
//   Halt       in   forces StepPulse low, StepCount holds
//   StepPulse  out  registered one-cycle step enable
//   KeyHeld    out  debounced key state, 1 = pressed
//   StepCount  out  number of StepPulse assertions since reset (wraps)

module step_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RUN_DIV         = 12500000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             CLOCK_50,
    input  logic             ResetN,
    input  logic             StepKeyN,
    input  logic             RunMode,
    input  logic             Halt,
    output logic             StepPulse,
    output logic             KeyHeld,
    output logic [CNT_W-1:0] StepCount
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic            key_s1;
    logic            key_s2;
    state_t          state;
    state_t          state_nxt;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            press_done;
    logic            pulse_nxt;

    // Debounce FSM: next state, shared counter, press acceptance strobe.
    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        press_done = 1'b0;
        case (state)
            IDLE: begin
                if (!key_s2) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (key_s2) begin
                    state_nxt = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = PRESSED;
                    press_done = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (key_s2) state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (!key_s2) begin
                    state_nxt = PRESSED;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    db_cnt_nxt = db_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // One counter serves both wait states, so every transition restarts it.
        if (state_nxt != state) db_cnt_nxt = '0;
    end

    assign KeyHeld = (state == PRESSED) || (state == RELEASE_WAIT);

`ifdef STEP_PULSE_AUTO_RUN_EN
    localparam int unsigned     PS_W    = $clog2(RUN_DIV);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(RUN_DIV - 1);

    logic [PS_W-1:0] presc;
    logic [PS_W-1:0] presc_nxt;
    logic            auto_fire;

    // Prescaler sits at 0 whenever run mode is off or halted, so any RunMode
    // change or Halt restarts the full RUN_DIV interval.
    always_comb begin
        presc_nxt = presc;
        auto_fire = 1'b0;
        if (!RunMode || Halt) begin
            presc_nxt = '0;
        end else if (presc == PS_LAST) begin
            presc_nxt = '0;
            auto_fire = 1'b1;
        end else begin
            presc_nxt = presc + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!ResetN) presc <= '0;
        else         presc <= presc_nxt;
    end

    assign pulse_nxt = !Halt && (RunMode ? auto_fire : press_done);
`else
    logic unused_run_mode;
    assign unused_run_mode = RunMode;
    assign pulse_nxt       = !Halt && press_done;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!ResetN) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            state     <= IDLE;
            db_cnt    <= '0;
            StepPulse <= 1'b0;
            StepCount <= '0;
        end else begin
            key_s1    <= StepKeyN;
            key_s2    <= key_s1;
            state     <= state_nxt;
            db_cnt    <= db_cnt_nxt;
            StepPulse <= pulse_nxt;
            if (StepPulse) StepCount <= StepCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen
//   Self-checking bench for step_pulse_gen (DEBOUNCE_CYCLES=4, RUN_DIV=5,
//   CNT_W=4). A behavioural model tracks how long the synchronized key has
//   disagreed with the debounced state and flips that state after D+1 such
//   samples; outputs are compared every cycle. Directed scenarios pin latency
//   and counts with literal values, followed by a randomized phase.
//   Auto-run scenarios are included when STEP_PULSE_AUTO_RUN_EN is defined.

module tb_step_pulse_gen;

    localparam int D  = 4;
    localparam int RD = 5;
    localparam int CW = 4;
`ifdef STEP_PULSE_AUTO_RUN_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          ResetN = 1'b0;
    logic          StepKeyN = 1'b1;
    logic          RunMode = 1'b0;
    logic          Halt = 1'b0;
    logic          StepPulse;
    logic          KeyHeld;
    logic [CW-1:0] StepCount;

    step_pulse_gen #(
        .DEBOUNCE_CYCLES(D),
        .RUN_DIV        (RD),
        .CNT_W          (CW)
    ) dut (
        .CLOCK_50 (clk),
        .ResetN   (ResetN),
        .StepKeyN (StepKeyN),
        .RunMode  (RunMode),
        .Halt     (Halt),
        .StepPulse(StepPulse),
        .KeyHeld  (KeyHeld),
        .StepCount(StepCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_sync[2];   // key delayed by two edges, oldest in [1]
    bit            m_held;
    int            m_disagree;  // consecutive samples opposing the debounced state
    int            m_age;       // edges spent in active auto-run since last pulse/start
    bit            m_pulse;
    logic [CW-1:0] m_count;

    always @(posedge clk) begin
        bit s, man_fire, auto_fire;
        cyc++;
        if (!ResetN) begin
            m_sync[0] = 1'b1; m_sync[1] = 1'b1;
            m_held = 1'b0; m_disagree = 0; m_age = 0;
            m_pulse = 1'b0; m_count = '0;
        end else begin
            if (m_pulse) m_count = m_count + 1'b1;
            s = m_sync[1];
            man_fire = 1'b0;
            auto_fire = 1'b0;
            if ((s == 1'b0) != m_held) begin
                m_disagree++;
                if (m_disagree == D + 1) begin
                    m_held = !m_held;
                    m_disagree = 0;
                    man_fire = m_held;
                end
            end else begin
                m_disagree = 0;
            end
            if (AUTO && RunMode && !Halt) begin
                m_age++;
                if (m_age == RD) begin
                    auto_fire = 1'b1;
                    m_age = 0;
                end
            end else begin
                m_age = 0;
            end
            m_pulse = !Halt && ((AUTO && RunMode) ? auto_fire : man_fire);
            m_sync[1] = m_sync[0];
            m_sync[0] = StepKeyN;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("pulse", StepPulse, m_pulse);
            check("held", KeyHeld, m_held);
            check("count", StepCount, m_count);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        ResetN = 1'b0;
        repeat (2) @(negedge clk);
        ResetN = 1'b1;
        started = 1'b1;
    endtask

    // Drive key for n cycles, counting pulses seen.
    task automatic hold(input logic key, input int n, output int np);
        StepKeyN = key;
        np = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (StepPulse === 1'b1) np++;
        end
    endtask

    // Hold key low and measure edges from first low sample to the pulse.
    task automatic press_latency(input int n, output int lat, output int np, output logic held_at);
        int c0;
        StepKeyN = 1'b0;
        c0 = cyc + 1;
        lat = 0; np = 0; held_at = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (StepPulse === 1'b1) begin
                np++;
                if (lat == 0) begin
                    lat = cyc - c0 + 1;
                    held_at = KeyHeld;
                end
            end
        end
    endtask

    initial begin
        int np, tot, lat;
        logic h;

        // 1: clean press
        do_reset();
        check("rst_pulse", StepPulse, 0);
        check("rst_held", KeyHeld, 0);
        check("rst_count", StepCount, 0);
        hold(1'b1, 3, np);
        press_latency(20, lat, np, h);
        check("t1_latency", lat, 7);
        check("t1_pulses", np, 1);
        check("t1_held_at_pulse", h, 1);
        check("t1_count", StepCount, 1);
        hold(1'b1, 10, np);

        // 2: bounce then stable
        do_reset();
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            hold(i[0], 1, np);
            tot += np;
        end
        check("t2_bounce_pulses", tot, 0);
        hold(1'b0, 15, np);
        check("t2_pulses", np, 1);
        check("t2_count", StepCount, 1);
        hold(1'b1, 10, np);

        // 3: 17 presses wrap the 4-bit counter
        do_reset();
        tot = 0;
        for (int i = 0; i < 17; i++) begin
            hold(1'b0, 10, np); tot += np;
            hold(1'b1, 10, np); tot += np;
        end
        check("t3_pulses", tot, 17);
        check("t3_count_wrap", StepCount, 1);

        // 4: halt swallows a press
        do_reset();
        hold(1'b0, 10, np);
        hold(1'b1, 10, np);
        Halt = 1'b1;
        hold(1'b0, 10, np); tot = np;
        hold(1'b1, 10, np); tot += np;
        check("t4_halt_pulses", tot, 0);
        check("t4_halt_count", StepCount, 1);
        Halt = 1'b0;
        hold(1'b0, 10, np);
        check("t4_after_halt_pulses", np, 1);
        hold(1'b1, 10, np);
        check("t4_after_halt_count", StepCount, 2);

`ifdef STEP_PULSE_AUTO_RUN_EN
        // 5: auto-run cadence, key press mid-run adds nothing
        begin
            int c0, mask;
            do_reset();
            RunMode = 1'b1;
            c0 = cyc + 1;
            mask = 0; tot = 0;
            for (int i = 0; i < 21; i++) begin
                if (i == 7) StepKeyN = 1'b0;
                if (i == 17) StepKeyN = 1'b1;
                @(negedge clk);
                if (StepPulse === 1'b1) begin
                    tot++;
                    if (cyc - c0 + 1 < 31) mask |= 1 << (cyc - c0 + 1);
                end
            end
            check("t5_pulses", tot, 4);
            check("t5_pulse_edges", mask, (1 << 5) | (1 << 10) | (1 << 15) | (1 << 20));
            check("t5_count", StepCount, 4);
            RunMode = 1'b0;
            hold(1'b1, 10, np);
        end
`endif

        // 6: reset during PRESS_WAIT restarts the whole sequence
        do_reset();
        hold(1'b0, 4, np);
        ResetN = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_rst_count", StepCount, 0);
        check("t6_rst_pulse", StepPulse, 0);
        ResetN = 1'b1;
        press_latency(15, lat, np, h);
        check("t6_latency", lat, 7);
        check("t6_pulses", np, 1);
        hold(1'b1, 10, np);

        // randomized phase
        do_reset();
        for (int i = 0; i < 400; i++) begin
            Halt = ($urandom_range(0, 7) == 0);
            if (AUTO) RunMode = ($urandom_range(0, 3) == 0);
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 9), np);
        end
        Halt = 1'b0;
        RunMode = 1'b0;
        hold(1'b1, 10, np);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Clock-enable source for the single-cycle processor's step clock input.
- Takes the raw active-low step pushbutton and produces a clean one-cycle StepPulse per physical press. The button is synchronized, debounced and edge-detected.
- Optionally free-runs at a fixed divided rate.
- Sits between the board key and the processor. The processor and display logic consume StepPulse and StepCount.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a press or release (10 ms at 50 MHz); minimum 2.
- RUN_DIV, 12500000, cycles between auto-run pulses (4 Hz at 50 MHz); minimum 2.
- CNT_W, 16, width of StepCount.

Ports:
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- ResetN  input  1  synchronous reset, active-low.
- StepKeyN  input  1  raw pushbutton, asynchronous, active-low (0 = pressed).
- RunMode  input  1  1 = auto-run (only with AUTO_RUN_EN), 0 = manual single-step.
- Halt  input  1  processor halt; suppresses all pulses while 1.
- StepPulse  output  1  one-cycle step enable to the processor.
- KeyHeld  output  1  debounced button state (1 = pressed).
- StepCount  output  CNT_W  number of StepPulse assertions since reset.

Behaviour:
- Reset (ResetN=0 at a clock edge):
  - Sync flops load 1.
  - State goes to IDLE; debounce counter and run prescaler go to 0.
  - StepPulse=0, KeyHeld=0, StepCount=0.
  - Reset overrides everything and applies mid-debounce or mid-run with no pending pulse preserved.
- Synchronizer: two flops on StepKeyN, giving signal s. The FSM sees only s, never the raw input.
- Debounce FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. A single counter is used and is cleared on every state change.
  - IDLE: s=0 -> PRESS_WAIT.
  - PRESS_WAIT: counts cycles with s=0.
    - s=1 before the count completes -> IDLE (bounce rejected).
    - Count reaches DEBOUNCE_CYCLES-1 with s=0 -> PRESSED.
  - PRESSED: KeyHeld=1. s=1 -> RELEASE_WAIT.
  - RELEASE_WAIT: KeyHeld=1. Counts cycles with s=1.
    - s=0 before the count completes -> PRESSED.
    - Count reaches DEBOUNCE_CYCLES-1 -> IDLE.
- Manual pulse:
  - StepPulse=1 for exactly the first cycle in PRESSED, entered from PRESS_WAIT.
  - Re-entry into PRESSED from RELEASE_WAIT does not pulse.
  - Latency from the first clock edge sampling StepKeyN=0: 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (IDLE->PRESS_WAIT) edges, provided the key is held stable.
  - Holding the key produces exactly one pulse; there is no auto-repeat.
- Halt:
  - While Halt=1, StepPulse is forced 0 and StepCount holds.
  - The debounce FSM still runs, so a press completing during Halt is lost, not queued.
  - Halt is sampled in the same cycle the pulse would be issued.
- StepCount: increments by 1 in the cycle after each StepPulse=1 and wraps from 2^CNT_W-1 to 0.
- StepPulse is a registered output. It is never high on two consecutive cycles in manual mode.

Optional Feature:
- Macro: STEP_PULSE_AUTO_RUN_EN.
- Defined:
  - With RunMode=1 and Halt=0, the prescaler counts 0..RUN_DIV-1.
  - StepPulse=1 for one cycle each time the prescaler is at RUN_DIV-1; the prescaler then wraps to 0.
  - Manual pulses are suppressed in run mode. KeyHeld still tracks the button.
  - Any change of RunMode, or Halt=1, clears the prescaler to 0, so the first auto pulse after run mode is entered or Halt is released arrives RUN_DIV cycles later.
- Not defined: RunMode is ignored, no prescaler is synthesized, and behaviour is manual-only.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=5, CNT_W=4):
1. Reset with StepKeyN=1, then drive StepKeyN=0 and hold for 20 cycles -> exactly one StepPulse, 7 edges after the first low sample. KeyHeld=1 coincides with the pulse; StepCount=1.
2. Bounce StepKeyN as 0,1,0,1 (1 cycle each), then 0 held -> no pulse during bounce; one pulse after the stable hold; StepCount=1.
3. Apply 17 clean press/release pairs -> StepCount reads 1 after the 17th press (wrap from 15 to 0).
4. Halt=1 through a full press/release -> StepPulse stays 0 and StepCount unchanged. Halt=0 then a new press -> one pulse.
5. With STEP_PULSE_AUTO_RUN_EN, RunMode=1 held for 20 cycles -> pulses at cycles 5, 10, 15, 20 after RunMode rises, with StepCount=4. Pressing the key mid-run adds no extra pulse.
6. Assert ResetN=0 during PRESS_WAIT, release reset, keep the key held -> no pulse until a full 2+DEBOUNCE_CYCLES+1 sequence completes. StepCount=0 after reset.
